// File: rtl/hs_fifo_if.sv
// rtl/hs_fifo_if.sv - upstream/downstream handshake bundle for hs_fifo
interface hs_fifo_if #(
  parameter int data_width = 32
);
  logic                  up_req;
  logic                  up_ack;
  logic [data_width-1:0] up_din;
  logic                  dn_req;
  logic                  dn_ack;
  logic [data_width-1:0] dn_dout;

  // master: the FIFO itself; slave: the producer/consumer environment
  modport master (
    output up_req,
    input  up_ack,
    input  up_din,
    input  dn_req,
    output dn_ack,
    output dn_dout
  );

  modport slave (
    input  up_req,
    output up_ack,
    output up_din,
    output dn_req,
    input  dn_ack,
    input  dn_dout
  );
endinterface

// File: rtl/hs_fifo.sv
// rtl/hs_fifo.sv - req/ack handshake FIFO with edge-detected push and paced pops
module hs_fifo #(
  parameter int data_width = 32,
  parameter int depth      = 4,
  parameter int addr_width = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  hs_fifo_if.master             bus,
  output logic [addr_width:0]   level,
  output logic                  overflow,
  output logic [31:0]           count_in,
  output logic [31:0]           count_out
);

  localparam logic [addr_width:0]   lvl_full = (addr_width+1)'(depth);
  localparam logic [addr_width:0]   lvl_high = (addr_width+1)'(depth - 2);
  localparam logic [addr_width:0]   lvl_one  = (addr_width+1)'(1);
  localparam logic [addr_width-1:0] ptr_one  = addr_width'(1);

  logic [data_width-1:0] mem [depth];
  logic [addr_width-1:0] wr_ptr;
  logic [addr_width-1:0] rd_ptr;
  logic                  ack_q;
  logic                  up_req_q;
  logic                  dn_ack_q;
  logic [data_width-1:0] dn_dout_q;
  logic                  push;
  logic                  pop;
  logic                  accept;
  logic [addr_width:0]   level_next;

  assign push   = bus.up_ack && !ack_q;
  assign pop    = bus.dn_req && !dn_ack_q && (level != '0);
  // a full FIFO still takes the word when a pop frees an entry this cycle
  assign accept = push && ((level != lvl_full) || pop);

  always_comb begin
    level_next = level;
    if (accept && !pop) begin
      level_next = level + lvl_one;
    end else if (pop && !accept) begin
      level_next = level - lvl_one;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_q     <= 1'b0;
      up_req_q  <= 1'b0;
      dn_ack_q  <= 1'b0;
      dn_dout_q <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      count_in  <= '0;
      count_out <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      ack_q    <= bus.up_ack;
      dn_ack_q <= pop;
      level    <= level_next;
      // one entry stays in reserve for an acknowledge already in flight
      up_req_q <= (level_next <= lvl_high);
      if (accept) begin
        wr_ptr   <= wr_ptr + ptr_one;
        count_in <= count_in + 32'd1;
      end
      if (push && !accept) begin
        overflow <= 1'b1;
      end
      if (pop) begin
        dn_dout_q <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + ptr_one;
        count_out <= count_out + 32'd1;
      end
    end
  end

  // storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= bus.up_din;
    end
  end

  assign bus.up_req  = up_req_q;
  assign bus.dn_ack  = dn_ack_q;
  assign bus.dn_dout = dn_dout_q;

endmodule

// File: tb/tb_hs_fifo.sv
// tb/tb_hs_fifo.sv - directed vector bench for hs_fifo
module tb_hs_fifo;

  typedef struct {
    logic        ack;
    logic [31:0] din;
    logic        req;
    logic [2:0]  lvl;
    logic        ureq;
    logic        dack;
    logic [31:0] dout;
    logic        ovf;
    logic [31:0] cin;
    logic [31:0] cout;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  level;
  logic        overflow;
  logic [31:0] count_in;
  logic [31:0] count_out;
  int          errors = 0;
  int          checks = 0;
  vec_t        vecs [24];

  hs_fifo_if #(.data_width(32)) bus ();

  hs_fifo #(.data_width(32), .depth(4), .addr_width(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .level     (level),
    .overflow  (overflow),
    .count_in  (count_in),
    .count_out (count_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic a, input logic [31:0] d, input logic r,
                              input logic [2:0] l, input logic u, input logic k,
                              input logic [31:0] o, input logic f,
                              input logic [31:0] ci, input logic [31:0] co);
    vec_t v;
    v.ack = a; v.din = d; v.req = r; v.lvl = l; v.ureq = u;
    v.dack = k; v.dout = o; v.ovf = f; v.cin = ci; v.cout = co;
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.up_ack = 1'b0;
    bus.dn_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic push(input logic [31:0] v);
    @(negedge clk);
    bus.up_ack = 1'b1;
    bus.up_din = v;
    @(negedge clk);
    bus.up_ack = 1'b0;
  endtask

  initial begin
    logic [31:0] got_q [$];
    int sent, got, cyc, first, last, ord_err;

    //            ack din req lvl ureq dack dout ovf cin cout
    vecs[0]  = mk(0, 0,  1,  0,  1,   0,   0,   0,  0,  0);
    vecs[1]  = mk(1, 1,  0,  1,  1,   0,   0,   0,  1,  0);
    vecs[2]  = mk(0, 0,  0,  1,  1,   0,   0,   0,  1,  0);
    vecs[3]  = mk(1, 2,  0,  2,  1,   0,   0,   0,  2,  0);
    vecs[4]  = mk(0, 0,  0,  2,  1,   0,   0,   0,  2,  0);
    vecs[5]  = mk(1, 3,  0,  3,  0,   0,   0,   0,  3,  0);
    vecs[6]  = mk(0, 0,  0,  3,  0,   0,   0,   0,  3,  0);
    vecs[7]  = mk(1, 4,  0,  4,  0,   0,   0,   0,  4,  0);
    vecs[8]  = mk(0, 0,  0,  4,  0,   0,   0,   0,  4,  0);
    vecs[9]  = mk(1, 5,  0,  4,  0,   0,   0,   1,  4,  0);
    vecs[10] = mk(1, 5,  0,  4,  0,   0,   0,   1,  4,  0);
    vecs[11] = mk(0, 0,  1,  3,  0,   1,   1,   1,  4,  1);
    vecs[12] = mk(0, 0,  1,  3,  0,   0,   1,   1,  4,  1);
    vecs[13] = mk(0, 0,  1,  2,  1,   1,   2,   1,  4,  2);
    vecs[14] = mk(1, 6,  1,  3,  0,   0,   2,   1,  5,  2);
    vecs[15] = mk(0, 0,  1,  2,  1,   1,   3,   1,  5,  3);
    vecs[16] = mk(0, 0,  1,  2,  1,   0,   3,   1,  5,  3);
    vecs[17] = mk(0, 0,  1,  1,  1,   1,   4,   1,  5,  4);
    vecs[18] = mk(0, 0,  1,  1,  1,   0,   4,   1,  5,  4);
    vecs[19] = mk(0, 0,  1,  0,  1,   1,   6,   1,  5,  5);
    vecs[20] = mk(0, 0,  1,  0,  1,   0,   6,   1,  5,  5);
    vecs[21] = mk(0, 0,  1,  0,  1,   0,   6,   1,  5,  5);
    vecs[22] = mk(1, 7,  1,  1,  1,   0,   6,   1,  6,  5);
    vecs[23] = mk(0, 0,  1,  0,  1,   1,   7,   1,  6,  6);

    bus.up_ack = 1'b0;
    bus.up_din = '0;
    bus.dn_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_up_req", bus.up_req, 0);
    chk("rst_dn_ack", bus.dn_ack, 0);
    chk("rst_level", level, 0);
    chk("rst_counts", {count_in, count_out}, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("up_req_before_edge", bus.up_req, 0);

    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      bus.up_ack = vecs[i].ack;
      bus.up_din = vecs[i].din;
      bus.dn_req = vecs[i].req;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_level", i), level, vecs[i].lvl);
      chk($sformatf("v%0d_up_req", i), bus.up_req, vecs[i].ureq);
      chk($sformatf("v%0d_dn_ack", i), bus.dn_ack, vecs[i].dack);
      chk($sformatf("v%0d_dn_dout", i), bus.dn_dout, vecs[i].dout);
      chk($sformatf("v%0d_overflow", i), overflow, vecs[i].ovf);
      chk($sformatf("v%0d_count_in", i), count_in, vecs[i].cin);
      chk($sformatf("v%0d_count_out", i), count_out, vecs[i].cout);
    end

    // full FIFO: pop and push edge together
    do_reset();
    push(10); push(11); push(12); push(13);
    #1;
    chk("full_level", level, 4);
    @(negedge clk);
    bus.up_ack = 1'b1;
    bus.up_din = 99;
    bus.dn_req = 1'b1;
    @(posedge clk);
    #1;
    chk("full_pp_level", level, 4);
    chk("full_pp_overflow", overflow, 0);
    chk("full_pp_dn_ack", bus.dn_ack, 1);
    chk("full_pp_dout", bus.dn_dout, 10);
    chk("full_pp_count_in", count_in, 5);
    @(negedge clk);
    bus.up_ack = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (bus.dn_ack) got_q.push_back(bus.dn_dout);
    end
    chk("drain_count", got_q.size(), 4);
    if (got_q.size() == 4) begin
      chk("drain_0", got_q[0], 11);
      chk("drain_1", got_q[1], 12);
      chk("drain_2", got_q[2], 13);
      chk("drain_3", got_q[3], 99);
    end

    // asynchronous reset with buffered words
    do_reset();
    push(21); push(22); push(23); push(24);
    @(negedge clk);
    bus.dn_req = 1'b1;
    @(negedge clk);
    bus.dn_req = 1'b0;
    chk("pre_rst_level", level, 3);
    chk("pre_rst_dout", bus.dn_dout, 21);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_level", level, 0);
    chk("arst_dout", bus.dn_dout, 0);
    chk("arst_up_req", bus.up_req, 0);
    chk("arst_counts", {count_in, count_out}, 0);
    @(negedge clk);
    rst = 1'b1;
    push(42);
    @(negedge clk);
    bus.dn_req = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_dn_ack", bus.dn_ack, 1);
    chk("post_rst_dout", bus.dn_dout, 42);

    // paced producer into always-ready consumer
    do_reset();
    bus.dn_req = 1'b1;
    sent = 0; got = 0; cyc = 0; first = -1; last = 0; ord_err = 0;
    while (got < 5000 && cyc < 30000) begin
      @(negedge clk);
      if (bus.up_ack) begin
        bus.up_ack = 1'b0;
      end else if (bus.up_req && sent < 5000) begin
        bus.up_din = sent;
        bus.up_ack = 1'b1;
        sent++;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (bus.dn_ack) begin
        if (bus.dn_dout !== 32'(got)) ord_err++;
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
    end
    chk("stream_got", got, 5000);
    chk("stream_order_errs", ord_err, 0);
    chk("stream_count_out", count_out, 5000);
    chk("stream_count_in", count_in, 5000);
    chk("stream_overflow", overflow, 0);
    chk("stream_span", last - first, 9998);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
